// File: rtl/clock_mode_pkg.sv
// clock_mode_pkg: shared constants, defaults and decode helpers for the
// clock setting-mode sequencer.
//   IDLE_IDX          - mode_idx value of the idle/display state
//   DEF_NUM_MODES     - default number of setting modes
//   DEF_TIMEOUT_TICKS - default inactivity timeout in seconds
//   MAX_MODES         - widest one-hot vector idx_to_onehot can produce
//   seq_event_e       - which rule, if any, moves the state this cycle
//   idx_to_onehot()   - mode_idx -> one-hot mode enable (idle -> all zero)
package clock_mode_pkg;

  localparam int IDLE_IDX          = 0;
  localparam int DEF_NUM_MODES     = 3;
  localparam int DEF_TIMEOUT_TICKS = 30;
  localparam int MAX_MODES         = 32;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_BACK,
    EV_MODE,
    EV_TIMEOUT
  } seq_event_e;

  // Index k+1 lights bit k; IDLE_IDX (and anything out of range) gives zero.
  function automatic logic [MAX_MODES-1:0] idx_to_onehot(input int unsigned idx);
    logic [MAX_MODES-1:0] oh;
    oh = '0;
    if (idx != IDLE_IDX && idx <= MAX_MODES)
      oh = {{(MAX_MODES-1){1'b0}}, 1'b1} << (idx - 1);
    return oh;
  endfunction

endpackage

// File: rtl/clock_mode_sequencer_if.sv
// clock_mode_sequencer_if: button-side inputs and setting-module enables of
// the mode sequencer, bundled as one port.
//   mode_btn, back_btn - debounced button levels
//   tick_1hz           - one-cycle pulse per second
//   activity           - high while an edit (inc/dec) button is pressed
//   mode_en            - one-hot enable of the active setting mode
//   idle               - high in the idle/display state
//   mode_idx           - 0 = idle, k+1 = mode k
//   timeout_evt        - one-cycle pulse on automatic return to idle
// master: button conditioning side; slave: the sequencer.
interface clock_mode_sequencer_if
  import clock_mode_pkg::*;
#(
  parameter int NUM_MODES = DEF_NUM_MODES,
  parameter int IDX_W     = $clog2(NUM_MODES + 1)
);

  logic                 mode_btn;
  logic                 back_btn;
  logic                 tick_1hz;
  logic                 activity;
  logic [NUM_MODES-1:0] mode_en;
  logic                 idle;
  logic [IDX_W-1:0]     mode_idx;
  logic                 timeout_evt;

  modport master (
    output mode_btn, back_btn, tick_1hz, activity,
    input  mode_en, idle, mode_idx, timeout_evt
  );

  modport slave (
    input  mode_btn, back_btn, tick_1hz, activity,
    output mode_en, idle, mode_idx, timeout_evt
  );

endinterface

// File: rtl/rise_detect.sv
// rise_detect: rising-edge detector for a debounced button level.
//   clk   - clock
//   rst_n - synchronous active-low reset
//   din   - button level
//   rise  - high for the cycle in which din is high and was low last cycle
// The previous-value flop resets to 1 so a button held through reset does not
// look like a fresh press when reset is released.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic prev_q;

  // NOTE: reset is sampled on the clock edge (synchronous), and sequential
  // state is always written with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!rst_n) prev_q <= 1'b1;
    else        prev_q <= din;
  end

  assign rise = din & ~prev_q;

endmodule

// File: rtl/clock_mode_sequencer.sv
// clock_mode_sequencer: cycles through NUM_MODES setting modes on the mode
// button, returns to idle on the back button or after TIMEOUT_TICKS seconds
// without user activity, and drives one-hot enables of the setting modules.
//   clk   - clock
//   rst_n - synchronous active-low reset
//   bus   - clock_mode_sequencer_if.slave (buttons, tick, activity in;
//           mode_en, idle, mode_idx, timeout_evt out, all registered)
// NUM_MODES must not exceed clock_mode_pkg::MAX_MODES.
module clock_mode_sequencer
  import clock_mode_pkg::*;
#(
  parameter int NUM_MODES     = DEF_NUM_MODES,
  parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
  parameter int IDX_W         = $clog2(NUM_MODES + 1),
  parameter int TMO_W         = (TIMEOUT_TICKS < 1) ? 1 : $clog2(TIMEOUT_TICKS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  clock_mode_sequencer_if.slave bus
);

  localparam logic [IDX_W-1:0] IDLE_STATE = IDX_W'(IDLE_IDX);
  localparam logic [IDX_W-1:0] LAST_STATE = IDX_W'(NUM_MODES);
  localparam bit               TMO_ON     = (TIMEOUT_TICKS > 0);
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TMO_ON ? TIMEOUT_TICKS - 1 : 0);
  localparam logic [TMO_W-1:0] TMO_MAX    = '1;

  logic mode_rise;
  logic back_rise;

  rise_detect u_mode_rise (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (bus.mode_btn),
    .rise (mode_rise)
  );

  rise_detect u_back_rise (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (bus.back_btn),
    .rise (back_rise)
  );

  logic [IDX_W-1:0]     state_q, state_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [NUM_MODES-1:0] mode_en_d;
  seq_event_e           ev;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    ev      = EV_NONE;
    state_d = state_q;
    tmo_d   = tmo_q;

    // Priority: back beats mode, and any button rise beats the timeout.
    // A back rise in idle therefore keeps idle and swallows a coincident mode rise.
    if (back_rise)
      ev = EV_BACK;
    else if (mode_rise)
      ev = EV_MODE;
    else if (TMO_ON && state_q != IDLE_STATE && bus.tick_1hz && !bus.activity &&
             tmo_q == TMO_LAST)
      ev = EV_TIMEOUT;

    case (ev)
      EV_BACK, EV_TIMEOUT: state_d = IDLE_STATE;
      EV_MODE:             state_d = (state_q == LAST_STATE) ? IDLE_STATE : state_q + 1'b1;
      default:             state_d = state_q;
    endcase

    // Inactivity counter only runs while sitting undisturbed in a setting mode.
    if (!TMO_ON || state_d != state_q || bus.activity || state_q == IDLE_STATE)
      tmo_d = '0;
    else if (bus.tick_1hz && tmo_q != TMO_MAX)
      tmo_d = tmo_q + 1'b1;
  end

  assign mode_en_d = NUM_MODES'(idx_to_onehot(32'(state_d)));

  // Outputs are decoded from the next state so they change on the same edge
  // as mode_idx, keeping every output a plain flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE_STATE;
      tmo_q           <= '0;
      bus.mode_en     <= '0;
      bus.idle        <= 1'b1;
      bus.timeout_evt <= 1'b0;
    end else begin
      state_q         <= state_d;
      tmo_q           <= tmo_d;
      bus.mode_en     <= mode_en_d;
      bus.idle        <= (state_d == IDLE_STATE);
      bus.timeout_evt <= (ev == EV_TIMEOUT);
    end
  end

  assign bus.mode_idx = state_q;

endmodule

// File: doc/clock_mode_sequencer.md
# clock_mode_sequencer

Parametrised setting-mode sequencer for the digital clock, and the next generation of the fixed four-state idle/time/date/alarm controller. It cycles through `NUM_MODES` setting modes on a mode button and returns to idle on a back button. It also returns to idle automatically after `TIMEOUT_TICKS` seconds without user activity. It sits between the button conditioning logic and the time/date/alarm setting modules, and drives their one-hot enables.

## Interface
- `NUM_MODES`, default 3 — number of setting modes (≥1); mode k enables setting module k.
- `TIMEOUT_TICKS`, default 30 — seconds of inactivity before auto-return to idle; 0 disables the timeout.
- `IDX_W`, default `$clog2(NUM_MODES+1)` — width of `mode_idx`.
- `TMO_W`, default `$clog2(TIMEOUT_TICKS+1)` (minimum 1) — width of the timeout counter.

Ports:
- `clk` in 1 — single clock.
- `rst_n` in 1 — reset is synchronous and active-low.
- `mode_btn` in 1 — debounced mode-button level; its rising edge advances the mode.
- `back_btn` in 1 — debounced back-button level; its rising edge returns to idle.
- `tick_1hz` in 1 — one-cycle pulse once per second.
- `activity` in 1 — level, high while any edit button (inc/dec) is pressed; restarts the timeout.
- `mode_en` out `NUM_MODES` — one-hot enable of the active setting mode; all zero in idle.
- `idle` out 1 — high in idle (display) state.
- `mode_idx` out `IDX_W` — 0 = idle, k+1 = mode k.
- `timeout_evt` out 1 — one-cycle pulse when the timeout forces a return to idle.

## Operation
- States: IDLE and MODE_0 … MODE_{NUM_MODES-1}. Encoded as `mode_idx` = 0 … NUM_MODES.
- Edge detection:
  - Each button input is registered into a previous-value flop.
  - A rise is the current input high while the previous value is low.
  - Previous-value flops reset to 1, so a button held through reset causes no event.
- Transitions, evaluated in priority order each cycle:
  1. Back rise: from any MODE_k → IDLE. In IDLE it is ignored.
  2. Mode rise: IDLE → MODE_0; MODE_k → MODE_{k+1}; last mode → IDLE (wrap).
  3. Timeout expiry, in MODE_k only: → IDLE, and `timeout_evt` = 1 for one cycle.
- Timeout counter:
  - Cleared on any state change, while `activity` = 1, and in IDLE.
  - Otherwise increments on `tick_1hz`.
  - Expiry is `tick_1hz` = 1 with counter = `TIMEOUT_TICKS`-1, `activity` = 0 and no button rise.
  - Counter saturates and never wraps.
  - With `TIMEOUT_TICKS` = 0 the counter is held at 0 and no expiry occurs.
- Simultaneous events:
  - Back and mode rising together → IDLE (back wins).
  - A button rise in the same cycle as expiry → the button transition applies and there is no `timeout_evt`.
  - `activity` in the same cycle as the final tick → no expiry.
- `NUM_MODES` = 1: mode rise toggles IDLE ↔ MODE_0.

## Timing
- All outputs are registered, with no combinational input-to-output path.
- Reset values: `idle` = 1, `mode_en` = 0, `mode_idx` = 0, `timeout_evt` = 0, timeout counter = 0, button previous-value flops = 1.
- Latency:
  - Input rise present before edge E → new state visible after edge E (1 cycle).
  - `timeout_evt` is asserted in the same cycle as the return to IDLE.
- Holding a button produces exactly one event; the button must drop and rise again to produce another.
- Reset asserted mid-mode: next edge forces IDLE, clears the counter and drops `timeout_evt`.
- Invariant: exactly one of `idle`, `mode_en[k]` is high, and `mode_idx` is consistent with it, in every cycle.

## Structure
- Package `clock_mode_pkg` contains:
  - `IDLE_IDX` = 0;
  - default values `DEF_NUM_MODES` = 3 and `DEF_TIMEOUT_TICKS` = 30;
  - the function `idx_to_onehot(idx)` used for `mode_en` decode.
- Sub-module `rise_detect` (clk, rst_n, din, rise; previous-value flop resets to 1), instantiated twice, for mode and back.
- Top contains the state register, next-state logic, timeout counter and output registers.

## Test plan
- Reset then 4 `mode_btn` presses (`NUM_MODES` = 3) → `mode_idx` sequence 1, 2, 3, 0; `mode_en` sequence 001, 010, 100, 000; each change 1 cycle after the rise.
- Enter MODE_1, then `back_btn` rise → `mode_idx` = 0 next cycle. `back_btn` rise in IDLE → no change.
- `TIMEOUT_TICKS` = 3, enter MODE_0, give 3 ticks with no activity → IDLE after the 3rd tick with `timeout_evt` high exactly 1 cycle. Repeat with `activity` pulsed after 2 ticks → still in MODE_0 after 4 ticks total and IDLE after 5.
- Mode and back rising in the same cycle while in MODE_0 → IDLE. Mode rise coincident with the expiring tick → MODE_1 and `timeout_evt` = 0.
- `mode_btn` held high through reset release and for 10 cycles → stays IDLE. Then release and press → MODE_0.
- `TIMEOUT_TICKS` = 0, in MODE_2 with 100 ticks → remains MODE_2. `rst_n` low for one cycle mid-mode → `idle` = 1 and `mode_en` = 0 next cycle.
